edge_bbox_tracker: RTL and testbench

//  Frame-level statistics stage directly downstream of the Sobel edge output (binary pixel stream).
//  Per frame: counts edge pixels (bit=1) and tracks their bounding box; latches results at end of frame.

---
 rtl/edge_bbox_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_edge_bbox_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/edge_bbox_tracker.sv
// rtl/edge_bbox_tracker.sv - per-frame edge-pixel count and bounding box over a binary pixel stream
module edge_bbox_tracker #(
    parameter logic [11:0] IMG_HDISP  = 12'd1920,
    parameter logic [11:0] IMG_VDISP  = 12'd1080,
    parameter logic [20:0] MIN_PIXELS = 21'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_bit,
    output logic [11:0] box_xmin,
    output logic [11:0] box_xmax,
    output logic [11:0] box_ymin,
    output logic [11:0] box_ymax,
    output logic [20:0] edge_count,
    output logic        box_valid,
    output logic        box_update,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_ACTIVE   = 2'd1,
        S_LATCH    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vsync_d;
    logic        r_href_d;
    logic        r_clken_d;
    logic        r_bit_d;
    logic        r_seen_low;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [20:0] r_count;
    logic        r_have;
    logic        r_err;
    logic [11:0] r_xmin;
    logic [11:0] r_xmax;
    logic [11:0] r_ymin;
    logic [11:0] r_ymax;
    logic [11:0] r_box_xmin;
    logic [11:0] r_box_xmax;
    logic [11:0] r_box_ymin;
    logic [11:0] r_box_ymax;
    logic [20:0] r_edge_count;
    logic        r_box_valid;
    logic        r_box_update;
    logic        r_frame_err;

    logic        w_sof;
    logic        w_eof;
    logic        w_active;
    logic        w_acc;
    logic        w_in_range;
    logic        w_hit;
    logic        w_line_end;
    logic        w_start;
    logic        w_latch;
    logic [11:0] w_y_nxt;
    logic        w_err_nxt;

    // A rising edge only counts once vsync has been seen low since reset,
    // so a frame already in progress at reset release is ignored.
    assign w_sof      = r_seen_low & ~r_vsync_d & per_frame_vsync;
    assign w_eof      = r_vsync_d & ~per_frame_vsync;
    assign w_active   = (r_state == S_ACTIVE);
    assign w_acc      = w_active & per_frame_vsync & per_frame_href & per_frame_clken;
    assign w_in_range = (r_x < IMG_HDISP) && (r_y < IMG_VDISP);
    assign w_hit      = w_acc & w_in_range & per_img_bit;
    assign w_line_end = w_active & r_href_d & ~per_frame_href;
    assign w_latch    = w_active & w_eof;
    assign w_start    = (w_state_nxt == S_ACTIVE) && (r_state != S_ACTIVE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_SOF: if (w_sof) w_state_nxt = S_ACTIVE;
            S_ACTIVE:   if (w_eof) w_state_nxt = S_LATCH;
            S_LATCH:    w_state_nxt = w_sof ? S_ACTIVE : S_WAIT_SOF;
            default:    w_state_nxt = S_WAIT_SOF;
        endcase
    end

    // Next-cycle line/error values so a line ending on the EOF cycle is still judged.
    always_comb begin
        w_y_nxt = r_y;
        if (w_line_end && (r_x != 12'd0) && (r_y != 12'hfff))
            w_y_nxt = r_y + 12'd1;
        w_err_nxt = r_err
                  | (w_acc & ~w_in_range)
                  | (w_line_end & (r_x != IMG_HDISP))
                  | (w_latch & (w_y_nxt != IMG_VDISP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_SOF;
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_clken_d    <= 1'b0;
            r_bit_d      <= 1'b0;
            r_seen_low   <= 1'b0;
            r_x          <= 12'd0;
            r_y          <= 12'd0;
            r_count      <= 21'd0;
            r_have       <= 1'b0;
            r_err        <= 1'b0;
            r_xmin       <= 12'd0;
            r_xmax       <= 12'd0;
            r_ymin       <= 12'd0;
            r_ymax       <= 12'd0;
            r_box_xmin   <= 12'd0;
            r_box_xmax   <= 12'd0;
            r_box_ymin   <= 12'd0;
            r_box_ymax   <= 12'd0;
            r_edge_count <= 21'd0;
            r_box_valid  <= 1'b0;
            r_box_update <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vsync_d    <= per_frame_vsync;
            r_href_d     <= per_frame_href;
            r_clken_d    <= per_frame_clken;
            r_bit_d      <= per_img_bit;
            r_box_update <= w_latch;
            if (!per_frame_vsync)
                r_seen_low <= 1'b1;

            if (w_start) begin
                r_x     <= 12'd0;
                r_y     <= 12'd0;
                r_count <= 21'd0;
                r_have  <= 1'b0;
                r_err   <= 1'b0;
                r_xmin  <= 12'd0;
                r_xmax  <= 12'd0;
                r_ymin  <= 12'd0;
                r_ymax  <= 12'd0;
            end else if (w_active) begin
                r_err <= w_err_nxt;
                r_y   <= w_y_nxt;
                if (w_line_end)
                    r_x <= 12'd0;
                else if (w_acc && (r_x != 12'hfff))
                    r_x <= r_x + 12'd1;
                if (w_hit) begin
                    if (r_count != 21'h1fffff)
                        r_count <= r_count + 21'd1;
                    r_have <= 1'b1;
                    if (!r_have) begin
                        r_xmin <= r_x;
                        r_xmax <= r_x;
                        r_ymin <= r_y;
                        r_ymax <= r_y;
                    end else begin
                        if (r_x < r_xmin) r_xmin <= r_x;
                        if (r_x > r_xmax) r_xmax <= r_x;
                        if (r_y < r_ymin) r_ymin <= r_y;
                        if (r_y > r_ymax) r_ymax <= r_y;
                    end
                end
            end

            if (w_latch) begin
                r_edge_count <= r_count;
                r_frame_err  <= w_err_nxt;
                if (r_count >= MIN_PIXELS) begin
                    r_box_valid <= 1'b1;
                    r_box_xmin  <= r_xmin;
                    r_box_xmax  <= r_xmax;
                    r_box_ymin  <= r_ymin;
                    r_box_ymax  <= r_ymax;
                end else begin
                    r_box_valid <= 1'b0;
                    r_box_xmin  <= 12'd0;
                    r_box_xmax  <= 12'd0;
                    r_box_ymin  <= 12'd0;
                    r_box_ymax  <= 12'd0;
                end
            end
        end
    end

    assign post_frame_vsync = r_vsync_d;
    assign post_frame_href  = r_href_d;
    assign post_frame_clken = r_clken_d;
    assign post_img_bit     = r_bit_d;
    assign box_xmin         = r_box_xmin;
    assign box_xmax         = r_box_xmax;
    assign box_ymin         = r_box_ymin;
    assign box_ymax         = r_box_ymax;
    assign edge_count       = r_edge_count;
    assign box_valid        = r_box_valid;
    assign box_update       = r_box_update;
    assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// tb/tb_edge_bbox_tracker.sv - scoreboard bench for edge_bbox_tracker
module tb_edge_bbox_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync, href, clken, pbit;
    logic        post_vsync, post_href, post_clken, post_bit;
    logic [11:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic [20:0] edge_count;
    logic        box_valid, box_update, frame_err;

    typedef struct {
        int          cyc;
        logic [20:0] cnt;
        logic [11:0] x0, x1, y0, y1;
        logic        v, e;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   img [0:7][0:8];

    logic [70:0] prev_out = '0;
    logic [70:0] cur_out;
    logic [3:0]  prev_in = '0;
    logic        prev_rst = 1'b0;

    edge_bbox_tracker #(
        .IMG_HDISP (12'd8),
        .IMG_VDISP (12'd6),
        .MIN_PIXELS(21'd2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .per_frame_clken (clken),
        .per_img_bit     (pbit),
        .post_frame_vsync(post_vsync),
        .post_frame_href (post_href),
        .post_frame_clken(post_clken),
        .post_img_bit    (post_bit),
        .box_xmin        (box_xmin),
        .box_xmax        (box_xmax),
        .box_ymin        (box_ymin),
        .box_ymax        (box_ymax),
        .edge_count      (edge_count),
        .box_valid       (box_valid),
        .box_update      (box_update),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    assign cur_out = {edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_valid, frame_err};

    // Monitor: reset values, pass-through delay, result hold, scoreboard pops on box_update.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_zero", {31'd0, |{cur_out, box_update, post_vsync, post_href, post_clken, post_bit}}, 32'd0);
            prev_out = '0;
        end else begin
            if (prev_rst)
                chk("passthrough", {28'd0, post_vsync, post_href, post_clken, post_bit}, {28'd0, prev_in});
            if (box_update) begin
                if (sb.size() == 0) begin
                    chk("unexpected_update", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("update_cycle", cyc, got.cyc);
                    chk("edge_count", {11'd0, edge_count}, {11'd0, got.cnt});
                    chk("box_xmin", {20'd0, box_xmin}, {20'd0, got.x0});
                    chk("box_xmax", {20'd0, box_xmax}, {20'd0, got.x1});
                    chk("box_ymin", {20'd0, box_ymin}, {20'd0, got.y0});
                    chk("box_ymax", {20'd0, box_ymax}, {20'd0, got.y1});
                    chk("box_valid", {31'd0, box_valid}, {31'd0, got.v});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, got.e});
                end
            end else begin
                chk("result_hold", {31'd0, cur_out != prev_out}, 32'd0);
            end
            prev_out = cur_out;
        end
        prev_rst = rst_n;
        prev_in  = {vsync, href, clken, pbit};
    end

    function automatic exp_t mk(input int cnt, input int x0, input int x1,
                                input int y0, input int y1, input bit v, input bit e);
        exp_t r;
        r.cyc = 0;
        r.cnt = 21'(cnt);
        r.x0 = 12'(x0); r.x1 = 12'(x1); r.y0 = 12'(y0); r.y1 = 12'(y1);
        r.v = v; r.e = e;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 9; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic send_frame(input int nlines, input int long_row, input bit gaps,
                              input int rst_row, input bit report, input exp_t e);
        int len, px;
        vsync = 1'b1;
        repeat (3) tick();
        for (int r = 0; r < nlines; r++) begin
            len = (r == long_row) ? 9 : 8;
            px  = 0;
            href = 1'b1;
            while (px < len) begin
                if (r == rst_row && px == 3) begin
                    rst_n = 1'b0;
                    repeat (3) tick();
                    rst_n = 1'b1;
                end
                clken = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                pbit  = clken ? img[r][px] : 1'($urandom_range(0, 1));
                if (clken) px++;
                tick();
            end
            href = 1'b0; clken = 1'b0; pbit = 1'b0;
            repeat (2) tick();
        end
        vsync = 1'b0;
        if (report) begin
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; pbit = 1'b0;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        clear_img(); img[1][2] = 1; img[4][5] = 1;
        send_frame(6, -1, 1'b0, -1, 1'b1, mk(2, 2, 5, 1, 4, 1, 0));

        clear_img(); img[5][7] = 1;
        send_frame(6, -1, 1'b0, -1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));

        clear_img(); img[0][1] = 1; img[5][6] = 1; img[3][8] = 1;
        send_frame(6, 3, 1'b0, -1, 1'b1, mk(2, 1, 6, 0, 5, 1, 1));

        clear_img(); img[0][0] = 1; img[4][7] = 1;
        send_frame(5, -1, 1'b0, -1, 1'b1, mk(2, 0, 7, 0, 4, 1, 1));

        clear_img(); img[1][2] = 1; img[4][5] = 1;
        send_frame(6, -1, 1'b0, 2, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        send_frame(6, -1, 1'b0, -1, 1'b1, mk(2, 2, 5, 1, 4, 1, 0));

        send_frame(6, -1, 1'b1, -1, 1'b1, mk(2, 2, 5, 1, 4, 1, 0));

        repeat (10) tick();
        chk("pending_updates", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
